// File: rtl/bridge_arb_pkg.sv
// bridge_arb_pkg: shared types and constants for the two-master bridge arbiter.
//   state_e     - FSM state encoding (IDLE, XFER, RESP)
//   OWN_M0/M1   - owner encoding for the granted master
//   TMO_CYC_DEF - default XFER timeout length in cycles
package bridge_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int unsigned TMO_CYC_DEF = 16;

endpackage

// File: rtl/bridge_arb_rr.sv
// bridge_arb_rr: two-way round-robin pick.
//   i_m0_req, i_m1_req - master requests
//   i_last             - owner granted last time (OWN_M0 / OWN_M1)
//   o_grant            - some master is requesting
//   o_owner            - master to grant this cycle
module bridge_arb_rr
  import bridge_arb_pkg::*;
(
  input  logic i_m0_req,
  input  logic i_m1_req,
  input  logic i_last,
  output logic o_grant,
  output logic o_owner
);

  always_comb begin
    o_grant = i_m0_req | i_m1_req;
    if (i_m0_req && i_m1_req) begin
      // Contention: the master not served last wins.
      o_owner = ~i_last;
    end else if (i_m1_req) begin
      o_owner = OWN_M1;
    end else begin
      o_owner = OWN_M0;
    end
  end

endmodule

// File: rtl/bridge_arb.sv
// bridge_arb: arbitrates a CPU master (m0) and a DMA master (m1) onto a single
// device bridge. One transfer in flight at a time: IDLE -> XFER -> RESP -> IDLE.
//   i_clk, i_rst_n             - clock, asynchronous active-low reset
//   i_mX_req/we/addr/wd        - master request, direction, address, write data
//   o_mX_ack/rd/err            - completion pulse, read data, timeout flag
//   o_praddr, o_prwd           - bridge address / write data (0 outside XFER)
//   o_bridge_wen               - one-cycle device write commit
//   i_prrd, i_dev_rdy          - bridge read data, device access complete
// Optional feature: define BRIDGE_ARB_TIMEOUT_EN to abort a transfer after
// TMO_CYC XFER cycles without i_dev_rdy (ack with err set).
module bridge_arb
  import bridge_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_m0_req,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_wd,
  output logic          o_m0_ack,
  output logic [DW-1:0] o_m0_rd,
  output logic          o_m0_err,
  input  logic          i_m1_req,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_wd,
  output logic          o_m1_ack,
  output logic [DW-1:0] o_m1_rd,
  output logic          o_m1_err,
  output logic [AW-1:0] o_praddr,
  output logic [DW-1:0] o_prwd,
  output logic          o_bridge_wen,
  input  logic [DW-1:0] i_prrd,
  input  logic          i_dev_rdy
);

  state_e        r_state;
  logic          r_owner;
  logic          r_last;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_m0_rd;
  logic [DW-1:0] r_m1_rd;

  logic w_grant;
  logic w_owner;
  logic w_timeout;
  logic w_xfer;
  logic w_resp;

  assign w_xfer = (r_state == XFER);
  assign w_resp = (r_state == RESP);

  bridge_arb_rr u_rr (
    .i_m0_req (i_m0_req),
    .i_m1_req (i_m1_req),
    .i_last   (r_last),
    .o_grant  (w_grant),
    .o_owner  (w_owner)
  );

`ifdef BRIDGE_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Counts completed XFER cycles; abort decision is taken in the last one.
  assign w_timeout = w_xfer && !i_dev_rdy && (r_cnt == CW'(TMO_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == IDLE && w_grant) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_m0_err = w_resp && r_err && (r_owner == OWN_M0);
  assign o_m1_err = w_resp && r_err && (r_owner == OWN_M1);
`else
  // No abort path; TMO_CYC is referenced only so the parameter stays live.
  assign w_timeout = 1'b0 && (TMO_CYC != 0);
  assign o_m0_err  = 1'b0;
  assign o_m1_err  = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_owner <= OWN_M0;
      r_last  <= OWN_M1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_m0_rd <= '0;
      r_m1_rd <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= XFER;
            r_owner <= w_owner;
            r_last  <= w_owner;
            r_we    <= w_owner ? i_m1_we   : i_m0_we;
            r_addr  <= w_owner ? i_m1_addr : i_m0_addr;
            r_wd    <= w_owner ? i_m1_wd   : i_m0_wd;
          end
        end
        XFER: begin
          if (i_dev_rdy) begin
            r_state <= RESP;
            if (!r_we) begin
              if (r_owner == OWN_M1) r_m1_rd <= i_prrd;
              else                   r_m0_rd <= i_prrd;
            end
          end else if (w_timeout) begin
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_praddr     = w_xfer ? r_addr : '0;
  assign o_prwd       = w_xfer ? r_wd   : '0;
  assign o_bridge_wen = r_we && w_xfer && i_dev_rdy;
  assign o_m0_ack     = w_resp && (r_owner == OWN_M0);
  assign o_m1_ack     = w_resp && (r_owner == OWN_M1);
  assign o_m0_rd      = r_m0_rd;
  assign o_m1_rd      = r_m1_rd;

endmodule

// File: doc/bridge_arb.md
BRIDGE_ARB -- requirements
Module: bridge_arb

Interface
REQ-001 Parameter AW, default 32, address width of both master ports and the bridge port.
REQ-002 Parameter DW, default 32, data width of both master ports and the bridge port.
REQ-003 Parameter TMO_CYC, default 16, maximum number of XFER cycles before abort; only used under BRIDGE_ARB_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 m0_req / m1_req  input  1  master request (m0 = CPU, m1 = DMA); held high until that master's ack.
REQ-007 m0_we / m1_we  input  1  1 = write, 0 = read; held stable while req is high.
REQ-008 m0_addr / m1_addr  input  AW  byte address; held stable while req is high.
REQ-009 m0_wd / m1_wd  input  DW  write data; held stable while req is high.
REQ-010 m0_ack / m1_ack  output  1  one-cycle completion pulse to the owning master.
REQ-011 m0_rd / m1_rd  output  DW  read data; valid in the ack cycle and held until the next ack to that master.
REQ-012 m0_err / m1_err  output  1  high with ack when the transfer timed out.
REQ-013 praddr  output  AW  address to the bridge.
REQ-014 prwd  output  DW  write data to the bridge.
REQ-015 bridge_wen  output  1  one-cycle device write commit.
REQ-016 prrd  input  DW  read data from the bridge.
REQ-017 dev_rdy  input  1  device has completed the current access this cycle.

Function
REQ-018 The FSM SHALL have states IDLE, XFER and RESP.
REQ-019 IDLE -> XFER on any req: latch owner, we, addr and wd from the granted master.
REQ-020 Single request: grant it. Both requests in the same cycle: grant the master not granted last (round-robin). First grant after reset goes to m0.
REQ-021 In XFER, praddr and prwd SHALL drive the latched values; outside XFER they are 0.
REQ-022 bridge_wen = latched we AND state==XFER AND dev_rdy; it SHALL never be high outside XFER.
REQ-023 XFER -> RESP when dev_rdy=1: capture prrd into the owner's rd register for a read; leave it unchanged for a write.
REQ-024 In RESP, exactly the owner's ack SHALL be high for one cycle; then RESP -> IDLE unconditionally.
REQ-025 Minimum latency SHALL be req sampled at edge N, ack high in cycle N+2 (dev_rdy high in the first XFER cycle).
REQ-026 Requests are never preempted; a request arriving during XFER/RESP waits and is arbitrated in the next IDLE cycle.
REQ-027 The last-grant pointer SHALL update only on the IDLE -> XFER transition.
REQ-028 A req deasserted before its ack is a protocol violation; the block completes the latched transfer regardless.

Reset
REQ-029 On rst=0 (asynchronous): state = IDLE, last-grant pointer selects m1 (so m0 wins first), ack/err = 0, rd = 0, bridge_wen = 0, praddr = 0, prwd = 0, timeout counter = 0.
REQ-030 Reset during XFER SHALL abort the transfer with no ack and no bridge_wen pulse.

Configuration
REQ-031 With macro BRIDGE_ARB_TIMEOUT_EN defined: a counter SHALL run in XFER, clear on entry, and abort at TMO_CYC cycles without dev_rdy (-> RESP, ack=1, err=1, rd unchanged, no bridge_wen).
REQ-032 Without BRIDGE_ARB_TIMEOUT_EN: no counter is built, err outputs are tied to 0, and XFER waits indefinitely for dev_rdy.

Structure
REQ-033 Shared package bridge_arb_pkg SHALL hold the state enum (IDLE/XFER/RESP), owner encoding (OWN_M0=0, OWN_M1=1) and the default TMO_CYC constant.
REQ-034 The 2-way round-robin pick SHALL be a sub-module bridge_arb_rr (inputs: two reqs and the last pointer; outputs: grant and owner).

Verification
REQ-035 m0 read addr 0x7F00, dev_rdy immediate, prrd=0x1234ABCD -> m0_ack in cycle N+2, m0_rd=0x1234ABCD, no bridge_wen.
REQ-036 m1 write addr 0x7F04 wd=0x55, dev_rdy after 3 cycles -> a single bridge_wen pulse with praddr=0x7F04 and prwd=0x55, then m1_ack on the next cycle.
REQ-037 m0 and m1 both request continuously from reset -> grants alternate m0, m1, m0, m1 with no back-to-back ack gap shorter than 3 cycles.
REQ-038 With BRIDGE_ARB_TIMEOUT_EN and dev_rdy held 0 -> after 16 XFER cycles: m0_ack=1, m0_err=1, bridge_wen never asserted.
REQ-039 rst pulled low mid-XFER of a write -> all outputs 0 immediately; after release a fresh m1 request completes normally.
